four_bank_mem: RTL and testbench

Four-way interleaved main-memory model that sits directly downstream of the cache controller and serves its `mem_*` request stream. Consecutive halfwords are spread across four banks, so line fills and evictions can issue back-to-back. Each bank is occupied for a fixed 4-cycle bank cycle and reports that on its own busy bit. Read data returns with a fixed 2-cycle latency.

---
 rtl/four_bank_mem_pkg.sv | 20 ++
 rtl/four_bank_mem_if.sv | 16 +
 rtl/four_bank_mem_bank.sv | 46 ++++
 rtl/four_bank_mem.sv | 62 ++++++
 tb/tb_four_bank_mem.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/four_bank_mem_pkg.sv
// Shared constants and types for the four-way interleaved main-memory model.
package four_bank_mem_pkg;
   localparam int NUM_BANKS  = 4;
   localparam int BANK_CYCLE = 4;
   localparam int RD_LAT     = 2;
   localparam int BSEL_LSB   = 1;
   localparam int BSEL_MSB   = 2;
   localparam int CNT_W      = 2;

   typedef logic [BSEL_MSB-BSEL_LSB:0] bank_sel_t;

   typedef struct packed {
      logic        vld;
      logic [15:0] data;
   } rd_stage_t;

   function automatic bank_sel_t bank_of(input logic [15:0] addr);
      return addr[BSEL_MSB:BSEL_LSB];
   endfunction
endpackage

// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller and the banked memory.
interface four_bank_mem_if;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic [15:0] DataOut;
   logic        stall;
   logic [four_bank_mem_pkg::NUM_BANKS-1:0] busy;
   logic        err;

   modport master (output Addr, DataIn, Rd, Wr,
                   input  DataOut, stall, busy, err);
   modport slave  (input  Addr, DataIn, Rd, Wr,
                   output DataOut, stall, busy, err);
endinterface

// File: rtl/four_bank_mem_bank.sv
// One memory bank: word storage, bank-cycle down-counter and accept logic.
module mem_bank
   import four_bank_mem_pkg::*;
#(
   parameter int BANK_AW = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sel_i,
   input  logic               rd_i,
   input  logic               wr_i,
   input  logic [BANK_AW-1:0] idx_i,
   input  logic [15:0]        din_i,
   output logic [15:0]        dout_o,
   output logic               busy_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      mem_q [2**BANK_AW];
   logic             acc;

   assign busy_o = (cnt_q != '0);
   assign acc    = sel_i & (rd_i | wr_i) & ~busy_o;
   assign dout_o = mem_q[idx_i];

   // Counter loads BANK_CYCLE-1 so busy covers the three cycles after accept.
   always_comb begin
      cnt_d = cnt_q;
      if (acc)
         cnt_d = CNT_W'(BANK_CYCLE - 1);
      else if (busy_o)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (acc && wr_i)
         mem_q[idx_i] <= din_i;
   end
endmodule

// File: rtl/four_bank_mem.sv
// Four-way interleaved memory: request decode, stall/err, 2-stage read return.
module four_bank_mem
   import four_bank_mem_pkg::*;
#(
   parameter int BANK_AW = 13
) (
   input  logic            clk,
   input  logic            rst,
   four_bank_mem_if.slave  bus
);
   bank_sel_t              bsel;
   logic                   req, illegal, legal, acc_rd;
   logic [NUM_BANKS-1:0]   busy_w, sel_w;
   logic [15:0]            dout_w [NUM_BANKS];
   logic [BANK_AW-1:0]     idx;
   rd_stage_t              st1_q, st1_d, st2_q, st2_d;

   assign bsel = bank_of(bus.Addr);
   assign idx  = bus.Addr[BANK_AW+2:3];

   always_comb begin
      req     = bus.Rd | bus.Wr;
      illegal = req & ((bus.Rd & bus.Wr) | bus.Addr[0]);
      legal   = req & ~illegal;
      sel_w   = '0;
      if (legal)
         sel_w[bsel] = 1'b1;
      acc_rd  = legal & bus.Rd & ~busy_w[bsel];
      st1_d.vld  = acc_rd;
      st1_d.data = acc_rd ? dout_w[bsel] : 16'h0000;
      st2_d   = st1_q;
   end

   assign bus.err     = illegal;
   assign bus.stall   = legal & busy_w[bsel];
   assign bus.busy    = busy_w;
   assign bus.DataOut = st2_q.vld ? st2_q.data : 16'h0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st1_q <= '0;
         st2_q <= '0;
      end else begin
         st1_q <= st1_d;
         st2_q <= st2_d;
      end
   end

   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      mem_bank #(.BANK_AW(BANK_AW)) u_bank (
         .clk    (clk),
         .rst    (rst),
         .sel_i  (sel_w[i]),
         .rd_i   (bus.Rd),
         .wr_i   (bus.Wr),
         .idx_i  (idx),
         .din_i  (bus.DataIn),
         .dout_o (dout_w[i]),
         .busy_o (busy_w[i])
      );
   end
endmodule

// File: tb/tb_four_bank_mem.sv
// Randomized scoreboard bench for four_bank_mem against a cycle-level reference model.
module tb_four_bank_mem;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   four_bank_mem_if bus ();
   four_bank_mem dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int          due;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q [$];
   logic [15:0] ref_mem [int];
   int          free_at [4];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: DataOut must carry queued read data on its due cycle, zero otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_lost: data %h due cycle %0d never returned", exp_q[0].data, exp_q[0].due);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("DataOut", {16'h0, bus.DataOut}, {16'h0, exp_q[0].data});
            void'(exp_q.pop_front());
         end else begin
            chk("DataOut_idle", {16'h0, bus.DataOut}, 32'h0);
         end
      end
   end

   task automatic drive(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] din, output bit accepted, output bit stalled);
      int   b;
      bit   e_err, e_legal, bsy;
      logic [3:0] e_busy;
      @(negedge clk);
      bus.Rd = rd; bus.Wr = wr; bus.Addr = addr; bus.DataIn = din;
      #1;
      b       = int'(addr[2:1]);
      e_err   = (rd || wr) && ((rd && wr) || addr[0]);
      e_legal = (rd || wr) && !e_err;
      for (int i = 0; i < 4; i++) e_busy[i] = (cyc < free_at[i]);
      bsy     = e_busy[b];
      chk("err",   {31'h0, bus.err},   {31'h0, e_err});
      chk("stall", {31'h0, bus.stall}, {31'h0, e_legal && bsy});
      chk("busy",  {28'h0, bus.busy},  {28'h0, e_busy});
      accepted = e_legal && !bsy;
      stalled  = e_legal && bsy;
      if (accepted) begin
         free_at[b] = cyc + 4;
         if (wr) ref_mem[int'(addr)] = din;
         else exp_q.push_back('{due: cyc + 2,
                                data: ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'hxxxx});
      end
   endtask

   task automatic idle(input int n);
      bit a, s;
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 16'h0, a, s);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      bus.Rd = 1'b0; bus.Wr = 1'b0;
      #3 rst = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 4; i++) free_at[i] = 0;
      #1;
      chk("rst_DataOut", {16'h0, bus.DataOut}, 32'h0);
      chk("rst_busy",    {28'h0, bus.busy},    32'h0);
      #1 rst = 1'b0;
   endtask

   initial begin
      bit a, s;
      int tries;
      logic [15:0] addr, din;
      int r;
      bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = 16'h0; bus.DataIn = 16'h0;
      for (int i = 0; i < 4; i++) free_at[i] = 0;
      #2;
      chk("reset_DataOut", {16'h0, bus.DataOut}, 32'h0);
      chk("reset_busy",    {28'h0, bus.busy},    32'h0);
      chk("reset_stall",   {31'h0, bus.stall},   32'h0);
      chk("reset_err",     {31'h0, bus.err},     32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Write then read-back after the bank cycle.
      drive(1'b0, 1'b1, 16'h0010, 16'hBEEF, a, s);
      chk("beef_wr_acc", {31'h0, a}, 32'h1);
      idle(3);
      drive(1'b1, 1'b0, 16'h0010, 16'h0, a, s);
      chk("beef_rd_acc", {31'h0, a}, 32'h1);
      idle(3);

      // Line evict then fill across all four banks.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 16'h0100 + 16'(2*i), 16'h1111 * 16'(i+1), a, s);
         chk("evict_acc", {31'h0, a}, 32'h1);
      end
      idle(4);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 16'h0100 + 16'(2*i), 16'h0, a, s);
         chk("fill_acc", {31'h0, a}, 32'h1);
      end
      idle(3);

      // Same-bank conflict with a held request.
      drive(1'b0, 1'b1, 16'h0008, 16'hA5A5, a, s);
      drive(1'b0, 1'b1, 16'h001A, 16'h0000, a, s);
      idle(3);
      drive(1'b0, 1'b1, 16'h0018, 16'h5A5A, a, s);
      idle(4);
      drive(1'b1, 1'b0, 16'h0008, 16'h0, a, s);
      tries = 0;
      do begin
         drive(1'b1, 1'b0, 16'h0018, 16'h0, a, s);
         tries++;
      end while (!a && tries < 8);
      chk("conflict_tries", tries, 4);
      idle(3);

      // Illegal requests.
      drive(1'b1, 1'b1, 16'h0000, 16'h0, a, s);
      chk("illegal_both", {31'h0, a}, 32'h0);
      drive(1'b1, 1'b0, 16'h0001, 16'h0, a, s);
      chk("illegal_odd", {31'h0, a}, 32'h0);
      idle(3);

      // Reset in the middle of a read, then an immediate re-read of that bank.
      drive(1'b1, 1'b0, 16'h0010, 16'h0, a, s);
      pulse_reset();
      drive(1'b1, 1'b0, 16'h0010, 16'h0, a, s);
      chk("post_reset_acc", {31'h0, a}, 32'h1);
      idle(3);

      // Randomized traffic; a stalled requester holds and retries.
      for (int n = 0; n < 400; n++) begin
         r    = int'($urandom_range(0, 99));
         addr = 16'($urandom_range(0, 63)) << 1;
         if ($urandom_range(0, 1) == 1) addr = addr | 16'h8000;
         din  = 16'($urandom);
         if (r < 10) begin
            idle(1);
         end else if (r < 16) begin
            if (r < 13) drive(1'b1, 1'b1, addr, din, a, s);
            else        drive(r[0], !r[0], addr | 16'h1, din, a, s);
         end else begin
            bit rd;
            rd = (r >= 55) && ref_mem.exists(int'(addr));
            tries = 0;
            do begin
               drive(rd, !rd, addr, din, a, s);
               tries++;
            end while (s && tries < 6);
            if (!a) begin
               n_checks++;
               n_fail++;
               $display("FAIL retry_bound: request to %h never accepted", addr);
            end
         end
      end
      idle(4);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
